io_input_conditioner: RTL
=========================

Name: io_input_conditioner

Overview:
- Conditions raw board inputs (32 slide switches, 4 push buttons) before they reach the pipeline core.
- Outputs drive the core's switch and button inputs, which the LSU exposes as memory-mapped IO.
- Each bit gets a 2-flop synchroniser, then a per-bit debounce counter.
- Also produces a single-cycle press pulse per button for event-driven use.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a level change is accepted (10 ms at 50 MHz); legal range >= 2.
- BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed; outputs are always active-high.
- SW_DEBOUNCE, 1, 1 = switches are debounced like buttons; 0 = switches are synchronised only.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_sw_raw  input  32  asynchronous raw switch levels.
- i_btn_raw  input  4  asynchronous raw button levels; polarity set by BTN_ACTIVE_LOW.
- o_io_sw  output  32  synchronised, debounced switch levels; connects to the core's i_io_sw.
- o_io_btn  output  4  synchronised, debounced, active-high button levels; connects to the core's i_io_btn.
- o_btn_press  output  4  one-cycle pulse per button on an accepted press.

Behaviour:
Clock and reset:
- Single clock domain; i_clk and i_rst_n are named as throughout the codebase.
- Reset is synchronous, active-low.
- While i_rst_n=0 at a rising edge:
  - sync flops load the idle value: 0 for switches; 0 for buttons after polarity normalisation, i.e. raw 1 when BTN_ACTIVE_LOW=1.
  - counters load 0.
  - o_io_sw=0, o_io_btn=0, o_btn_press=0.
- Reset asserted mid-debounce discards all progress; no pulse is emitted in the reset cycle or the cycle after.

Polarity:
- Button bits are inverted before synchronisation when BTN_ACTIVE_LOW=1.
- All logic downstream of the inversion is active-high.

Synchroniser:
- Chain is ff1 <- raw, ff2 <- ff1.
- ff2 is the "synced" value.

Per-bit debounce (36 independent instances; switches only when SW_DEBOUNCE=1):
- Counter width is $clog2(DEBOUNCE_CYCLES); it saturates at no value other than by the rule below.
- If synced == stable: counter <= 0.
- If synced != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
- If synced != stable and counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0.
- Any glitch back to the stable value restarts the count from 0. A change must hold for the full window.

Latency:
- A raw level first sampled at edge k, and held, appears on the output after edge k+DEBOUNCE_CYCLES+1.
- With SW_DEBOUNCE=0, the switch path is the synchroniser alone: o_io_sw = ff2, latency 2 edges.

Press pulse:
- o_btn_press[i] is registered.
- It is 1 for exactly one cycle: the cycle in which o_io_btn[i] first reads 1 after reading 0.
- Release (1->0) produces no pulse.
- Multiple buttons may pulse in the same cycle.

Outputs:
- All outputs are registered; there is no combinational path from raw inputs to outputs.

Test Plan:
1. Reset: hold i_rst_n=0 for 3 cycles with i_sw_raw=32'hFFFF_FFFF and i_btn_raw=4'h0 (BTN_ACTIVE_LOW=1) -> o_io_sw=0, o_io_btn=0, o_btn_press=0 throughout reset.
2. Clean press (DEBOUNCE_CYCLES=4): drive i_btn_raw[0]=0, first sampled at edge k -> o_io_btn[0] rises after edge k+5; o_btn_press[0]=1 for exactly that one cycle. Release -> o_io_btn[0] falls 5 edges later with no pulse.
3. Bounce rejection (DEBOUNCE_CYCLES=4): toggle i_sw_raw[7] with pattern 1,1,1,0,1,1,1,1 (one value per cycle) -> o_io_sw[7] stays 0 until 4 consecutive synced 1s, rising exactly 5 edges after the final 0->1 sample.
4. Simultaneous events: i_sw_raw=32'hA5A5_0F0F and all four buttons pressed on the same edge -> o_io_sw=32'hA5A5_0F0F and o_io_btn=4'hF update on the same edge; o_btn_press=4'hF for one cycle.
5. Reset mid-operation: press button 2, assert reset after 2 counted cycles, release reset with the button still pressed -> no pulse during or after reset; o_io_btn[2] rises DEBOUNCE_CYCLES+1 edges after the first post-reset sample, with a single pulse.
6. SW_DEBOUNCE=0: step i_sw_raw 0 -> 32'h1234_5678 -> o_io_sw=32'h1234_5678 exactly 2 edges later; a one-cycle glitch propagates unfiltered.

Source files
------------

// File: rtl/io_input_conditioner_if.sv
// Board-side IO bundle between the raw switch/button pins and the conditioner.
// The master drives the raw pins; the slave (the conditioner) returns the clean levels and press pulses.
interface io_input_conditioner_if;
  logic [31:0] i_sw_raw;
  logic [3:0]  i_btn_raw;
  logic [31:0] o_io_sw;
  logic [3:0]  o_io_btn;
  logic [3:0]  o_btn_press;

  modport master (
    output i_sw_raw,
    output i_btn_raw,
    input  o_io_sw,
    input  o_io_btn,
    input  o_btn_press
  );

  modport slave (
    input  i_sw_raw,
    input  i_btn_raw,
    output o_io_sw,
    output o_io_btn,
    output o_btn_press
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Synchronises and debounces 32 switches and 4 buttons (buttons normalised to active-high),
// and emits a one-cycle pulse when a button press is accepted.
module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter bit SW_DEBOUNCE     = 1'b1
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  io_input_conditioner_if.slave  io
);

  localparam int N_SW  = 32;
  localparam int N_BTN = 4;
  localparam int N     = N_SW + N_BTN;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Lowest bit index that goes through a debounce counter; switches skip it when not debounced.
  localparam int DB_LO = SW_DEBOUNCE ? 0 : N_SW;

  logic [N-1:0]     raw_norm;
  logic [N-1:0]     ff1_q;
  logic [N-1:0]     ff2_q;
  logic [N-1:0]     stable_q;
  logic [N-1:0]     stable_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;

  assign raw_norm = {io.i_btn_raw ^ {N_BTN{BTN_ACTIVE_LOW}}, io.i_sw_raw};

  // A level change is accepted only after it has differed from the stable value for the whole window.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (i >= DB_LO && ff2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ff2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    press_d = stable_d[N-1:N_SW] & ~stable_q[N-1:N_SW];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ff1_q    <= '0;
      ff2_q    <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ff1_q    <= raw_norm;
      ff2_q    <= ff1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign io.o_io_sw     = SW_DEBOUNCE ? stable_q[N_SW-1:0] : ff2_q[N_SW-1:0];
  assign io.o_io_btn    = stable_q[N-1:N_SW];
  assign io.o_btn_press = press_q;

endmodule
